// File: rtl/seg7_capture_if.sv
// Segment-bus capture interface: sampled display lines in,
// committed digit state out.
interface seg7_capture_if;
   logic [7:0]  i_seg;
   logic [3:0]  i_an;
   logic [15:0] o_digits;
   logic [3:0]  o_valid;
   logic [3:0]  o_dp;
   logic        o_upd;
   logic        o_err;
   logic [1:0]  o_idx;

   modport master (
      output i_seg, i_an,
      input  o_digits, o_valid, o_dp, o_upd, o_err, o_idx
   );

   modport slave (
      input  i_seg, i_an,
      output o_digits, o_valid, o_dp, o_upd, o_err, o_idx
   );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment bus snooper: debounces {an, seg} samples and
// commits decoded BCD digits once a sample is stable.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input logic           i_clk,
   input logic           i_rst,
   seg7_capture_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      LOCKED
   } state_t;

   localparam logic [7:0] NMAX = 8'(STABLE_CYCLES);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [11:0] prev_q;
   logic [15:0] digits_q;
   logic [3:0]  valid_q;
   logic [3:0]  dp_q;
   logic        upd_q;
   logic        err_q;
   logic [1:0]  idx_q;

   logic [11:0] smp_d;
   logic        an_ok_d;
   logic [1:0]  sel_d;
   logic [3:0]  code_d;
   logic        legal_d;
   logic        blank_d;
   logic        same_d;
   logic [7:0]  cnt_inc_d;

   // Sample qualification: one-hot-low digit select and pattern decode
   always_comb begin
      smp_d     = {bus.i_an, bus.i_seg};
      same_d    = (smp_d == prev_q);
      cnt_inc_d = cnt_q + 8'd1;
      an_ok_d   = 1'b0;
      sel_d     = 2'd0;
      code_d    = 4'd0;
      legal_d   = 1'b1;
      blank_d   = 1'b0;
      unique case (bus.i_an)
         4'hE: begin an_ok_d = 1'b1; sel_d = 2'd0; end
         4'hD: begin an_ok_d = 1'b1; sel_d = 2'd1; end
         4'hB: begin an_ok_d = 1'b1; sel_d = 2'd2; end
         4'h7: begin an_ok_d = 1'b1; sel_d = 2'd3; end
         default: ;
      endcase
      unique case (bus.i_seg[6:0])
         7'h40: code_d = 4'd0;
         7'h79: code_d = 4'd1;
         7'h24: code_d = 4'd2;
         7'h30: code_d = 4'd3;
         7'h19: code_d = 4'd4;
         7'h12: code_d = 4'd5;
         7'h02: code_d = 4'd6;
         7'h78: code_d = 4'd7;
         7'h00: code_d = 4'd8;
         7'h10: code_d = 4'd9;
         7'h7F: begin legal_d = 1'b0; blank_d = 1'b1; end
         default: legal_d = 1'b0;
      endcase
   end

   // Stability FSM with commit of digit state and strobes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         prev_q   <= '1;
         digits_q <= '0;
         valid_q  <= '0;
         dp_q     <= '0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= 2'd0;
      end else begin
         upd_q  <= 1'b0;
         err_q  <= 1'b0;
         prev_q <= smp_d;
         if (!an_ok_d) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= COUNT;
                  cnt_q   <= 8'd1;
               end
               COUNT: begin
                  if (!same_d) begin
                     cnt_q <= 8'd1;
                  end else begin
                     cnt_q <= cnt_inc_d;
                     if (cnt_inc_d == NMAX) begin
                        state_q <= LOCKED;
                        idx_q   <= sel_d;
                        if (legal_d) begin
                           digits_q[{sel_d, 2'b00} +: 4] <= code_d;
                           valid_q[sel_d] <= 1'b1;
                           dp_q[sel_d]    <= ~bus.i_seg[7];
                           upd_q          <= 1'b1;
                        end else if (blank_d) begin
                           valid_q[sel_d] <= 1'b0;
                           dp_q[sel_d]    <= 1'b0;
                        end else begin
                           valid_q[sel_d] <= 1'b0;
                           err_q          <= 1'b1;
                        end
                     end
                  end
               end
               LOCKED: begin
                  if (!same_d) begin
                     state_q <= COUNT;
                     cnt_q   <= 8'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= 8'd0;
               end
            endcase
         end
      end
   end

   assign bus.o_digits = digits_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_dp     = dp_q;
   assign bus.o_upd    = upd_q;
   assign bus.o_err    = err_q;
   assign bus.o_idx    = idx_q;

endmodule
